// File: rtl/serial_frame_tx_if.sv
// Parallel-word handshake and serial output bundle for serial_frame_tx.
// The master side supplies words; the slave side (the transmitter) drives the bit stream and status.
interface serial_frame_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              dout;
   logic              busy;
   logic              frame_done;

   modport master (
      output din, din_valid,
      input  din_ready, dout, busy, frame_done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, dout, busy, frame_done
   );
endinterface

// File: rtl/serial_frame_tx.sv
// Bit-stuffed serial frame transmitter: PRE_LEN ones, separator 0, stuffed data MSB first, guard 0.
// First preamble bit one cycle after accept; din_ready only in IDLE, so words wait while a frame is out.
module serial_frame_tx #(
   parameter int PRE_LEN = 4,
   parameter int DATA_W  = 8
) (
   input logic               clk,
   input logic               ret,
   serial_frame_tx_if.slave  tx
);

   localparam int PW = $clog2(PRE_LEN + 1);
   localparam int BW = $clog2(DATA_W + 1);
   localparam int RW = $clog2(PRE_LEN);

   localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W);
   localparam logic [RW-1:0] RUN_MAX  = RW'(PRE_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_SEP   = 3'd2,
      S_DATA  = 3'd3,
      S_STUFF = 3'd4,
      S_GUARD = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [RW-1:0]     run_cnt_q, run_cnt_d;
   logic              dout_q, dout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rdy_q, rdy_d;
   logic              cur_bit;

   always_ff @(posedge clk or negedge ret) begin
      if (!ret) begin
         state_q   <= S_IDLE;
         sr_q      <= '0;
         pre_cnt_q <= '0;
         bit_cnt_q <= '0;
         run_cnt_q <= '0;
         dout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         pre_cnt_q <= pre_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         run_cnt_q <= run_cnt_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rdy_q     <= rdy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      pre_cnt_d = pre_cnt_q;
      bit_cnt_d = bit_cnt_q;
      run_cnt_d = run_cnt_q;
      cur_bit   = sr_q[DATA_W-1];

      case (state_q)
         S_IDLE: begin
            // rdy_q is the registered din_ready, so the first edge after reset never accepts
            if (tx.din_valid && rdy_q) begin
               sr_d      = tx.din;
               pre_cnt_d = '0;
               state_d   = S_PRE;
            end
         end
         S_PRE: begin
            pre_cnt_d = pre_cnt_q + PW'(1);
            if (pre_cnt_d == PRE_LAST) state_d = S_SEP;
         end
         S_SEP: begin
            run_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = S_DATA;
         end
         S_DATA: begin
            sr_d      = sr_q << 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            run_cnt_d = cur_bit ? run_cnt_q + RW'(1) : '0;
            // A stuff bit wins over the guard, even after the final data bit
            if (cur_bit && (run_cnt_d == RUN_MAX)) state_d = S_STUFF;
            else if (bit_cnt_d == BIT_LAST)        state_d = S_GUARD;
         end
         S_STUFF: begin
            run_cnt_d = '0;
            state_d   = (bit_cnt_q == BIT_LAST) ? S_GUARD : S_DATA;
         end
         S_GUARD: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            sr_d      = '0;
            pre_cnt_d = '0;
            bit_cnt_d = '0;
            run_cnt_d = '0;
         end
      endcase

      // Outputs are decoded from the next state so each register shows the bit of the cycle it enters
      dout_d = (state_d == S_PRE) || ((state_d == S_DATA) && sr_d[DATA_W-1]);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_GUARD);
      rdy_d  = (state_d == S_IDLE);
   end

   assign tx.dout       = dout_q;
   assign tx.busy       = busy_q;
   assign tx.frame_done = done_q;
   assign tx.din_ready  = rdy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: fixed frame vectors, back-to-back, reset abort and random words vs a stuffing model.
module tb_serial_frame_tx;

   localparam int PRE = 4;
   localparam int DW  = 8;

   logic clk = 1'b0;
   logic ret = 1'b0;

   serial_frame_tx_if #(.DATA_W(DW)) tx_if ();

   serial_frame_tx #(.PRE_LEN(PRE), .DATA_W(DW)) dut (
      .clk (clk),
      .ret (ret),
      .tx  (tx_if)
   );

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;
   bit cap_q[$];
   bit exp_q[$];
   int cap_done_idx;
   int cap_busy_bad;
   int cap_wait;
   int cap_idle_ok;

   typedef struct {
      logic [DW-1:0] din;
      int            len;
      int            pat;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Frame built straight from the rules: preamble, separator, data with a 0 after every PRE-1 ones, guard
   function automatic void build_model(input logic [DW-1:0] d);
      int run = 0;
      exp_q.delete();
      repeat (PRE) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      for (int i = DW - 1; i >= 0; i--) begin
         exp_q.push_back(d[i]);
         run = d[i] ? run + 1 : 0;
         if (run == PRE - 1) begin
            exp_q.push_back(1'b0);
            run = 0;
         end
      end
      exp_q.push_back(1'b0);
   endfunction

   function automatic int pack_cap(input int from, input int n);
      int v = 0;
      for (int i = from; i < from + n; i++) v = (v << 1) | ((i < cap_q.size()) ? int'(cap_q[i]) : 0);
      return v;
   endfunction

   function automatic int pack_exp();
      int v = 0;
      for (int i = 0; i < exp_q.size(); i++) v = (v << 1) | int'(exp_q[i]);
      return v;
   endfunction

   function automatic int det_fires(input int from, input int n);
      int run = 0;
      int fires = 0;
      for (int i = from; i < from + n && i < cap_q.size(); i++) begin
         run = cap_q[i] ? run + 1 : 0;
         if (run == PRE) fires++;
      end
      return fires;
   endfunction

   // Receiver: skip preamble and separator, drop the 0 that follows each run of PRE-1 ones
   function automatic int destuff(input int start);
      int idx = start + PRE + 1;
      int run = 0;
      int w = 0;
      bit b;
      for (int n = 0; n < DW; n++) begin
         b = (idx < cap_q.size()) ? cap_q[idx] : 1'b0;
         idx++;
         w = (w << 1) | int'(b);
         run = b ? run + 1 : 0;
         if (run == PRE - 1) begin
            idx++;
            run = 0;
         end
      end
      return w;
   endfunction

   task automatic wait_accept(input logic [DW-1:0] d, input bit hold);
      tx_if.din       = d;
      tx_if.din_valid = 1'b1;
      cap_wait        = 0;
      @(negedge clk);
      while (!tx_if.din_ready && cap_wait < 50) begin
         @(negedge clk);
         cap_wait++;
      end
      if (!tx_if.din_ready) check("accept_timeout", int'(tx_if.din_ready), 1);
      @(posedge clk);
      #1;
      if (!hold) begin
         tx_if.din_valid = 1'b0;
         tx_if.din       = DW'($urandom);
      end
   endtask

   task automatic capture_frame();
      cap_q.delete();
      cap_done_idx = -1;
      cap_busy_bad = 0;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         cap_q.push_back(tx_if.dout);
         if (!tx_if.busy) cap_busy_bad++;
         if (tx_if.frame_done) begin
            cap_done_idx = c;
            break;
         end
      end
      @(negedge clk);
      cap_idle_ok = int'(!tx_if.dout && !tx_if.busy && tx_if.din_ready && !tx_if.frame_done);
   endtask

   task automatic check_frame(input string tag, input logic [DW-1:0] d, input int len, input int pat);
      check({tag, "_len"}, cap_q.size(), len);
      check({tag, "_bits"}, pack_cap(0, cap_q.size()), pat);
      check({tag, "_done_pos"}, cap_done_idx, len - 1);
      check({tag, "_busy"}, cap_busy_bad, 0);
      check({tag, "_detector"}, det_fires(0, cap_q.size()), 1);
      check({tag, "_idle_after"}, cap_idle_ok, 1);
      check({tag, "_destuff"}, destuff(0), int'(d));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int l1, l2, tot, exp_rdy, exp_bsy, exp_done, got_rdy, got_bsy, got_done;
      bit seen;
      bit tmp_q[$];
      logic [DW-1:0] rd;

      vecs[0] = '{din: 8'h00, len: 14, pat: 32'h3C00};
      vecs[1] = '{din: 8'hFF, len: 16, pat: 32'hF776};
      vecs[2] = '{din: 8'hE7, len: 16, pat: 32'hF71C};
      vecs[3] = '{din: 8'hA5, len: 14, pat: 32'h3D4A};
      vecs[4] = '{din: 8'h3C, len: 15, pat: 32'h78E8};
      vecs[5] = '{din: 8'h81, len: 14, pat: 32'h3D02};

      tx_if.din       = 8'h00;
      tx_if.din_valid = 1'b1;
      ret             = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst%0d_dout", i), int'(tx_if.dout), 0);
         check($sformatf("rst%0d_ready", i), int'(tx_if.din_ready), 0);
         check($sformatf("rst%0d_busy", i), int'(tx_if.busy), 0);
      end
      ret = 1'b1;
      @(negedge clk);
      check("post_rst_ready", int'(tx_if.din_ready), 1);
      check("post_rst_busy", int'(tx_if.busy), 0);
      check("post_rst_dout", int'(tx_if.dout), 0);
      tx_if.din_valid = 1'b0;

      foreach (vecs[i]) begin
         wait_accept(vecs[i].din, 1'b0);
         capture_frame();
         check_frame($sformatf("vec%0d", i), vecs[i].din, vecs[i].len, vecs[i].pat);
      end

      // Back-to-back with din_valid held: A5 then 3C, one IDLE cycle between frames
      build_model(8'hA5);
      tmp_q = exp_q;
      l1 = exp_q.size();
      build_model(8'h3C);
      l2 = exp_q.size();
      tmp_q.push_back(1'b0);
      foreach (exp_q[i]) tmp_q.push_back(exp_q[i]);
      tmp_q.push_back(1'b0);
      exp_q = tmp_q;
      tot = l1 + 1 + l2 + 1;
      exp_rdy = 0; exp_bsy = 0; exp_done = 0;
      for (int i = 0; i < tot; i++) begin
         exp_rdy  = (exp_rdy << 1)  | int'(i == l1 || i == tot - 1);
         exp_bsy  = (exp_bsy << 1)  | int'(!(i == l1 || i == tot - 1));
         exp_done = (exp_done << 1) | int'(i == l1 - 1 || i == tot - 2);
      end
      wait_accept(8'hA5, 1'b1);
      tx_if.din = 8'h3C;
      cap_q.delete();
      got_rdy = 0; got_bsy = 0; got_done = 0;
      for (int c = 0; c < tot; c++) begin
         @(negedge clk);
         cap_q.push_back(tx_if.dout);
         got_rdy  = (got_rdy << 1)  | int'(tx_if.din_ready);
         got_bsy  = (got_bsy << 1)  | int'(tx_if.busy);
         got_done = (got_done << 1) | int'(tx_if.frame_done);
         seen = tx_if.din_ready;
         @(posedge clk);
         #1;
         if (seen) tx_if.din_valid = 1'b0;
      end
      check("b2b_bits", pack_cap(0, tot), pack_exp());
      check("b2b_ready", got_rdy, exp_rdy);
      check("b2b_busy", got_bsy, exp_bsy);
      check("b2b_done", got_done, exp_done);
      check("b2b_destuff_a", destuff(0), 32'hA5);
      check("b2b_destuff_b", destuff(l1 + 1), 32'h3C);
      check("b2b_detector", det_fires(0, tot), 2);

      // Reset during the third data bit of an all-ones word, then an immediate new frame
      wait_accept(8'hFF, 1'b0);
      repeat (8) @(negedge clk);
      check("abort_pre_dout", int'(tx_if.dout), 1);
      check("abort_pre_busy", int'(tx_if.busy), 1);
      ret = 1'b0;
      #1;
      check("abort_dout", int'(tx_if.dout), 0);
      check("abort_busy", int'(tx_if.busy), 0);
      check("abort_ready", int'(tx_if.din_ready), 0);
      @(negedge clk);
      @(negedge clk);
      ret = 1'b1;
      wait_accept(8'h81, 1'b0);
      check("abort_accept_wait", cap_wait, 0);
      capture_frame();
      check_frame("after_abort", 8'h81, vecs[5].len, vecs[5].pat);

      for (int r = 0; r < 30; r++) begin
         rd = DW'($urandom);
         build_model(rd);
         wait_accept(rd, 1'b0);
         capture_frame();
         check($sformatf("rnd%0d_%02h_len", r, rd), cap_q.size(), exp_q.size());
         check($sformatf("rnd%0d_%02h_bits", r, rd), pack_cap(0, cap_q.size()), pack_exp());
         check($sformatf("rnd%0d_%02h_done", r, rd), cap_done_idx, exp_q.size() - 1);
         check($sformatf("rnd%0d_%02h_detector", r, rd), det_fires(0, cap_q.size()), 1);
         check($sformatf("rnd%0d_%02h_destuff", r, rd), destuff(0), int'(rd));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that produces the single-bit stream consumed by the team's run-of-ones sequence detectors. It accepts a parallel word through a valid/ready handshake and emits, MSB first, a preamble of PRE_LEN consecutive ones, a separator zero, and the bit-stuffed data word. A closing guard zero ends the frame. Stuffing guarantees the data field never contains PRE_LEN consecutive ones, so a downstream detector fires only on the preamble.

## Interface
- PRE_LEN, 4: preamble length in ones; legal range 2..8. The stuff run length is PRE_LEN-1.
- DATA_W, 8: data word width; legal range 1..32.

- clk  input  1  clock; all state updates on rising edge
- ret  input  1  reset, asynchronous, active-low
- din  input  DATA_W  word to transmit, sampled on accept
- din_valid  input  1  din holds a word to send
- din_ready  output  1  block can accept a word this cycle
- dout  output  1  serial bit stream, registered
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse during the guard bit

## Operation
- Reset values (ret low): dout=0, busy=0, frame_done=0, din_ready=0, state IDLE, all counters 0, shift register 0.
- A word is accepted when din_valid and din_ready are both high on a clock edge. din_ready is high only in IDLE, and only after ret has been released.
- All outputs are registered. dout reflects the current state and bit.
- States:
  - IDLE: dout=0. On accept, load din into the shift register, then go to PRE with pre_cnt=0.
  - PRE: dout=1. pre_cnt increments each cycle. Go to SEP after PRE_LEN cycles.
  - SEP: dout=0 for 1 cycle. Clear run_cnt and bit_cnt, then go to DATA.
  - DATA: dout = current MSB of the shift register. Shift left and increment bit_cnt each cycle. If the bit is 1, increment run_cnt; otherwise clear run_cnt.
    - If the sent bit is 1 and run_cnt reaches PRE_LEN-1, go to STUFF. This applies even if it was the last data bit.
    - Otherwise, after bit_cnt reaches DATA_W, go to GUARD.
  - STUFF: dout=0 for 1 cycle. Clear run_cnt. Return to DATA if bits remain, else go to GUARD.
  - GUARD: dout=0, frame_done=1 for 1 cycle, then go to IDLE.
- busy = 1 in every state except IDLE.
- din_valid is ignored while not in IDLE. din is not required to stay stable after accept.
- Illegal or unreachable state encodings go to IDLE with dout=0.
- Reset mid-frame: outputs take their reset values immediately (asynchronously), and the partial frame is discarded. The first cycle after release is IDLE with din_ready=1.

## Timing
- Accept at edge k: dout=1 at cycle k+1, the first preamble bit.
- Frame length in cycles = PRE_LEN + 1 + DATA_W + S + 1, where S is the number of stuff bits.
- Back-to-back: at least one IDLE cycle (dout=0) separates frames. With din_valid held high, the next accept occurs in the first IDLE cycle.
- Longest run of ones in the data field is PRE_LEN-1. The longest run of ones across the whole frame is exactly PRE_LEN (the preamble).
- Counter widths:
  - pre_cnt: ceil(log2(PRE_LEN+1)) bits.
  - bit_cnt: ceil(log2(DATA_W+1)) bits.
  - run_cnt: ceil(log2(PRE_LEN)) bits.
  - No counter may wrap within a frame.

## Test plan
- Reset: hold ret low 3 cycles with din_valid=1 → dout=0, din_ready=0, busy=0 throughout. din_ready=1 on the first cycle after release.
- din=8'h00, defaults → dout sequence 1111 0 00000000 0, which is 14 cycles. frame_done is high only in cycle 14. A 4-ones detector on dout fires exactly once.
- din=8'hFF → 1111 0 111 0 111 0 11 0, which is 16 cycles with S=2. The detector fires once, in the preamble only.
- din=8'hE7 → 1111 0 111 0 00 111 0 0, which is 16 cycles. This shows the final-bit stuff followed by the guard.
- din_valid held high with words A5 then 3C → two frames separated by exactly one IDLE cycle. din_ready pulses high only in IDLE. A receiver model de-stuffs both words correctly.
- ret asserted in the 3rd data bit of a frame → dout=0 asynchronously. After release, an immediate new accept of 8'h81 → a correct 14-cycle frame with no residue from the aborted frame.
